rot_arb_ctrl_8: RTL and testbench



---
 rtl/rot_arb_ctrl_8.sv | 127 ++++++++++++
 tb/tb_rot_arb_ctrl_8.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_arb_ctrl_8.sv
// rtl/rot_arb_ctrl_8.sv - two-requester round-robin front end for an external 8-bit rotator
// Optional 16-bit handshake counter op_count enabled by ROT_ARB_CNT_EN.
module rot_arb_ctrl_8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_data,
   input  logic [2:0] req0_sel,
   input  logic       req0_left,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_data,
   input  logic [2:0] req1_sel,
   input  logic       req1_left,
   output logic [7:0] rot_data,
   output logic [2:0] rot_sel,
   output logic       rot_left,
   input  logic [7:0] rot_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_id,
   output logic       busy
`ifdef ROT_ARB_CNT_EN
   ,
   output logic [15:0] op_count
`endif
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROT = 2'd1, S_RESP = 2'd2} state_t;

   state_t     state_q, state_d;
   logic       last_grant_q;
   logic [7:0] rot_data_q;
   logic [2:0] rot_sel_q;
   logic       rot_left_q;
   logic [7:0] rsp_data_q;
   logic       rsp_id_q;
   logic       gnt0, gnt1, accept;

   // Grants are masked during reset so no ready leaks out while rst is high.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == S_IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign accept = gnt0 | gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ROT;
         S_ROT:   state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = gnt0;
      req1_ready = gnt1;
      rsp_valid  = (state_q == S_RESP);
      busy       = (state_q != S_IDLE);
   end

   // Rotator drive registers load only on acceptance, so they hold steady outside ROT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         rot_data_q   <= 8'h00;
         rot_sel_q    <= 3'd0;
         rot_left_q   <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= 8'h00;
      end else begin
         if (accept) begin
            last_grant_q <= gnt1;
            rsp_id_q     <= gnt1;
            rot_data_q   <= gnt1 ? req1_data : req0_data;
            rot_sel_q    <= gnt1 ? req1_sel  : req0_sel;
            rot_left_q   <= gnt1 ? req1_left : req0_left;
         end
         if (state_q == S_ROT) begin
            rsp_data_q <= rot_out;
         end
      end
   end

   assign rot_data = rot_data_q;
   assign rot_sel  = rot_sel_q;
   assign rot_left = rot_left_q;
   assign rsp_data = rsp_data_q;
   assign rsp_id   = rsp_id_q;

`ifdef ROT_ARB_CNT_EN
   logic [15:0] op_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_q <= 16'h0000;
      end else if (rsp_valid && rsp_ready) begin
         op_count_q <= op_count_q + 16'd1;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_rot_arb_ctrl_8.sv
// tb/tb_rot_arb_ctrl_8.sv - scoreboard bench for rot_arb_ctrl_8 with a behavioural rotator
`timescale 1ns/1ps
module tb_rot_arb_ctrl_8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic [2:0] req0_sel = 3'd0, req1_sel = 3'd0;
   logic       req0_left = 1'b0, req1_left = 1'b0;
   logic [7:0] rot_data;
   logic [2:0] rot_sel;
   logic       rot_left;
   logic [7:0] rot_out;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_id;
   logic       busy;
`ifdef ROT_ARB_CNT_EN
   logic [15:0] op_count;
`endif

   rot_arb_ctrl_8 dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req0_sel(req0_sel), .req0_left(req0_left),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .req1_sel(req1_sel), .req1_left(req1_left),
      .rot_data(rot_data), .rot_sel(rot_sel), .rot_left(rot_left), .rot_out(rot_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .busy(busy)
`ifdef ROT_ARB_CNT_EN
      , .op_count(op_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rot8(input logic [7:0] d, input logic [2:0] s, input logic l);
      int v, k, r;
      v = d;
      k = s;
      if (!l) k = (8 - k) % 8;
      r = ((v << k) | (v >> (8 - k))) & 255;
      return r[7:0];
   endfunction

   assign rot_out = rot8(rot_data, rot_sel, rot_left);

   int         checks = 0, failures = 0;
   int         cyc = 0, acc_cyc = -100, n_rsp = 0;
   bit         m_idle = 1'b1, m_last = 1'b1, seen = 1'b0;
   logic [8:0] sbq[$];
   logic [8:0] last_rsp = 9'h0;
   logic [11:0] exp_rot = 12'h0, prev_rot = 12'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One clock of stimulus; the model predicts the grant and queues the expected response.
   task automatic cyc_drive(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [2:0] s0, input logic [2:0] s1, input bit l0, input bit l1,
                            input bit rr, output int gid);
      int eg;
      @(negedge clk);
      req0_valid = v0; req1_valid = v1;
      req0_data = d0; req1_data = d1;
      req0_sel = s0; req1_sel = s1;
      req0_left = l0; req1_left = l1;
      rsp_ready = rr;
      #1;
      eg = -1;
      if (m_idle) begin
         if (v0 && v1) eg = m_last ? 0 : 1;
         else if (v0)  eg = 0;
         else if (v1)  eg = 1;
      end
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, eg == 0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, eg == 1});
      chk("busy", {31'b0, busy}, {31'b0, !m_idle});
      if (eg >= 0) begin
         if (eg == 0) begin
            sbq.push_back({1'b0, rot8(d0, s0, l0)});
            exp_rot = {d0, s0, l0};
         end else begin
            sbq.push_back({1'b1, rot8(d1, s1, l1)});
            exp_rot = {d1, s1, l1};
         end
         acc_cyc = cyc;
         m_idle  = 1'b0;
         m_last  = eg[0];
      end
      gid = eg;
   endtask

   task automatic idle_cyc(input bit rr);
      int g;
      cyc_drive(0, 0, 8'h00, 8'h00, 3'd0, 3'd0, 0, 0, rr, g);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!m_idle && n < 30) begin
         idle_cyc(1);
         n++;
      end
      chk("idle_timeout", {31'b0, m_idle}, 32'd1);
   endtask

   task automatic do_reset(input bit wait_edge);
      if (wait_edge) @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("reset_outputs",
          {rsp_valid, rsp_data, rsp_id, rot_data, rot_sel, rot_left, req0_ready, req1_ready, busy},
          32'd0);
      sbq.delete();
      m_idle = 1'b1; m_last = 1'b1; seen = 1'b0; acc_cyc = -100;
      repeat (2) @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic single(input bit who, input logic [7:0] d, input logic [2:0] s, input bit l);
      int g;
      if (who) cyc_drive(0, 1, 8'h00, d, 3'd0, s, 0, l, 1, g);
      else     cyc_drive(1, 0, d, 8'h00, s, 3'd0, l, 0, 1, g);
      chk("single_grant", g, {31'b0, who});
      wait_idle();
   endtask

   // Monitor: compares responses and rotator drive against the scoreboard each cycle.
   always @(negedge clk) begin
      #4;
      if (!rst) begin
         if (cyc == acc_cyc + 1)
            chk("rot_operands", {20'b0, rot_data, rot_sel, rot_left}, {20'b0, exp_rot});
         else
            chk("rot_hold", {20'b0, rot_data, rot_sel, rot_left}, {20'b0, prev_rot});
         if (rsp_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
               chk("rsp_id_data", {23'b0, rsp_id, rsp_data}, {23'b0, sbq[0]});
               if (!seen) chk("latency", cyc - acc_cyc, 32'd2);
               seen = 1'b1;
               if (rsp_ready) begin
                  last_rsp = sbq.pop_front();
                  m_idle = 1'b1;
                  seen = 1'b0;
                  n_rsp++;
               end
            end
         end else if (sbq.size() > 0 && cyc >= acc_cyc + 2) begin
            chk("rsp_missing", {31'b0, rsp_valid}, 32'd1);
         end
      end
      prev_rot = {rot_data, rot_sel, rot_left};
      cyc++;
   end

   initial begin
      int g, k, nr;
      int gids[$];
      do_reset(1);

      // single request, rotate right by 1
      cyc_drive(1, 0, 8'hA5, 8'h00, 3'd1, 3'd0, 0, 0, 1, g);
      chk("dir_grant", g, 32'd0);
      idle_cyc(1);
      chk("dir_rot_sel", {29'b0, rot_sel}, 32'd1);
      wait_idle();
      chk("dir_rsp", {23'b0, last_rsp}, {23'b0, 1'b0, 8'hD2});

      // tie with both held valid: grants alternate starting from 0
      do_reset(1);
      k = 0;
      while (gids.size() < 4 && k < 40) begin
         cyc_drive(1, 1, 8'h96, 8'h3C, 3'd2, 3'd5, 0, 1, 1, g);
         if (g >= 0) gids.push_back(g);
         k++;
      end
      chk("tie_count", gids.size(), 32'd4);
      for (int i = 0; i < gids.size(); i++) chk("tie_order", gids[i], i % 2);
      wait_idle();
      chk("tie_last_rsp", {23'b0, last_rsp}, {23'b0, 1'b1, 8'h87});

      // backpressure: both valid asserted while response is stalled
      cyc_drive(0, 1, 8'h00, 8'h5A, 3'd0, 3'd3, 0, 1, 0, g);
      nr = n_rsp;
      repeat (12) cyc_drive(1, 1, 8'h11, 8'h22, 3'd1, 3'd1, 0, 0, 0, g);
      chk("bp_no_rsp", n_rsp, nr);
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      wait_idle();
      chk("bp_one_rsp", n_rsp, nr + 1);
      chk("bp_rsp", {23'b0, last_rsp}, {23'b0, 1'b1, 8'hD2});

      // reset while in ROT
      cyc_drive(1, 0, 8'h42, 8'h00, 3'd4, 3'd0, 1, 0, 1, g);
      idle_cyc(1);
      nr = n_rsp;
      do_reset(0);
      repeat (6) idle_cyc(1);
      chk("rst_no_rsp", n_rsp, nr);

      // rotate amount 0 passes the operand through
      single(0, 8'h81, 3'd0, 1);
      chk("sel0_rsp", {23'b0, last_rsp}, {23'b0, 1'b0, 8'h81});
      single(1, 8'h81, 3'd0, 0);
      chk("sel0_rsp1", {23'b0, last_rsp}, {23'b0, 1'b1, 8'h81});

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cyc_drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, g);
      end
      wait_idle();

`ifdef ROT_ARB_CNT_EN
      do_reset(1);
      chk("cnt_reset", {16'b0, op_count}, 32'd0);
      for (int i = 0; i < 5; i++) single(i % 2, 8'(i + 1), 3'(i), i % 2);
      chk("cnt_five", {16'b0, op_count}, 32'd5);
      @(negedge clk);
      dut.op_count_q = 16'hFFFF;
      single(0, 8'h01, 3'd1, 1);
      chk("cnt_wrap", {16'b0, op_count}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout actual=%0d required=done", cyc);
      $fatal(1);
   end

endmodule
